// File: rtl/mux41_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux41_arb_pkg
// Shared types and constants for the 4-requester round-robin arbiter that
// drives the select pair of a 4:1 mux datapath.
//   state_e     : arbiter FSM states (IDLE, BUSY), 1-bit encoding
//   NREQ, IDX_W : requester count and index width
//   PTR_RST     : round-robin pointer after reset (requester 0 wins first)
//   idx2onehot  : index -> one-hot grant vector
// ---------------------------------------------------------------------------
package mux41_arb_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  localparam logic [IDX_W-1:0] PTR_RST = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic logic [NREQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux41_rr_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin picker. Scans req cyclically starting just after
// ptr (ptr+1, ptr+2, ptr+3, ptr) and returns the first requesting index.
// Ports:
//   req [3:0] in  : request vector
//   ptr [1:0] in  : index granted last (lowest priority this round)
//   idx [1:0] out : winning index (only meaningful when any = 1)
//   any       out : at least one request is present
// ---------------------------------------------------------------------------
module rr_pick4
  import mux41_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Walk the offsets from furthest (ptr itself) to nearest (ptr+1) so that
  // the nearest requester overwrites everything behind it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    idx  = ptr;
    cand = ptr;
    any  = |req;
    for (int k = NREQ; k >= 1; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux41_rr_arbiter
// Round-robin arbiter and sequencer sharing one WIDTH-bit output channel
// between four requesters. A grant is held for a whole burst; beats are
// forwarded from the granted requester over a valid/ready handshake through
// a 4:1 mux selected by the registered {s1,s0} pair.
//
// Parameters:
//   WIDTH     : data width per requester and on y
//   MAX_BURST : beats per grant before a forced release (1..15), only active
//               when the ARB_TIMEOUT_EN macro is defined
// Ports:
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   req[3:0]       : per-requester request
//   last[3:0]      : per-requester end-of-burst, qualified by that beat
//   A0..A3         : requester data
//   gnt[3:0]       : registered one-hot grant, zero when idle
//   s1, s0         : registered mux select, {s1,s0} = granted index
//   y              : granted requester's data via the 4:1 mux
//   y_valid        : beat present on y
//   y_ready        : downstream accepts the beat
//
// Build option: define ARB_TIMEOUT_EN to enable the per-grant beat limit.
// ---------------------------------------------------------------------------
module mux41_rr_arbiter
  import mux41_arb_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       last,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] A3,
  output logic [3:0]       gnt,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready
);

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("mux41_rr_arbiter: MAX_BURST must be within 1..15");
  end

  state_e           state_q;
  logic [NREQ-1:0]  gnt_q;
  logic [IDX_W-1:0] sel_q;
  logic [IDX_W-1:0] ptr_q;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             xfer;
  logic             abort;
  logic             rel_last;
  logic             rel_limit;
  logic             release_d;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // While BUSY, sel_q is the granted index, so the handshake is decoded from
  // it directly. y_valid follows req combinationally so an abort is seen in
  // the same cycle and no beat is counted.
  assign y_valid  = (state_q == BUSY) && req[sel_q];
  assign xfer     = y_valid && y_ready;
  assign abort    = (state_q == BUSY) && !req[sel_q];
  assign rel_last = xfer && last[sel_q];

`ifdef ARB_TIMEOUT_EN
  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  logic [3:0] beat_cnt_q;
  logic [3:0] beat_cnt_d;

  assign beat_cnt_d = beat_cnt_q + 4'd1;
  // Release on the transfer that brings the count up to the limit.
  assign rel_limit  = xfer && (beat_cnt_d == BURST_LIM);
`else
  assign rel_limit  = 1'b0;
`endif

  assign release_d = abort || rel_last || rel_limit;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= PTR_RST;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q <= BUSY;
            gnt_q   <= idx2onehot(pick_idx);
            sel_q   <= pick_idx;
          end
        end
        BUSY: begin
          // No preemption: only the granted requester can end the burst.
          if (release_d) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= sel_q;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      beat_cnt_q <= '0;
    end else if (xfer) begin
      beat_cnt_q <= beat_cnt_d;
    end
  end
`endif

  assign gnt = gnt_q;
  assign s1  = sel_q[1];
  assign s0  = sel_q[0];

  // 4:1 datapath mux; select is held through IDLE so y stays stable.
  always_comb begin
    y = A0;
    case ({s1, s0})
      2'd0:    y = A0;
      2'd1:    y = A1;
      2'd2:    y = A2;
      2'd3:    y = A3;
      default: y = A0;
    endcase
  end

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux41_rr_arbiter
// Self-checking bench for mux41_rr_arbiter. A behavioural model (integer
// pointer, busy flag, beat count) predicts gnt, {s1,s0}, y_valid and y.
// Directed scenarios cover reset, fairness, bursts, backpressure, abort,
// reset mid-burst and the optional beat limit; a random phase follows.
// ---------------------------------------------------------------------------
module tb_mux41_rr_arbiter;

  localparam int WIDTH     = 4;
  localparam int MAX_BURST = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req = '0;
  logic [3:0]       last = '0;
  logic [WIDTH-1:0] a_arr [4];
  logic [3:0]       gnt;
  logic             s1, s0;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // Model state
  bit m_busy = 1'b0;
  int m_idx  = 0;
  int m_ptr  = 3;
  int m_sel  = 0;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  mux41_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .last    (last),
    .A0      (a_arr[0]),
    .A1      (a_arr[1]),
    .A2      (a_arr[2]),
    .A3      (a_arr[3]),
    .gnt     (gnt),
    .s1      (s1),
    .s0      (s0),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_advance();
    if (rst) begin
      m_busy = 1'b0; m_ptr = 3; m_sel = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (req != 4'b0) begin
        for (int k = 1; k <= 4; k++) begin
          int c = (m_ptr + k) % 4;
          if (req[c]) begin m_idx = c; break; end
        end
        m_busy = 1'b1; m_sel = m_idx; m_cnt = 0;
      end
    end else begin
      bit rel = 1'b0;
      if (!req[m_idx]) rel = 1'b1;
      else if (y_ready) begin
        m_cnt++;
        if (last[m_idx]) rel = 1'b1;
        if (TIMEOUT && m_cnt == MAX_BURST) rel = 1'b1;
      end
      if (rel) begin m_busy = 1'b0; m_ptr = m_idx; end
    end
  endtask

  function automatic logic [3:0] exp_gnt();
    return m_busy ? 4'(1 << m_idx) : 4'b0;
  endfunction
  function automatic logic exp_valid();
    return m_busy && req[m_idx];
  endfunction
  function automatic logic [1:0] exp_sel();
    return 2'(m_sel);
  endfunction
  function automatic logic [WIDTH-1:0] exp_y();
    return a_arr[m_sel];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; last = '0; y_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) a_arr[i] = WIDTH'($urandom);
    do_reset();
    settle();
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if ({s1, s0} !== 2'b00) begin errors++; $display("FAIL reset_sel: got %b expected 00", {s1, s0}); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", y_valid); end
    checks++; if (y !== a_arr[0]) begin errors++; $display("FAIL reset_y: got %h expected %h", y, a_arr[0]); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    do_reset();
    req = 4'b1111; last = 4'b1111; y_ready = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      settle();
      exp = (c % 2 == 1) ? 4'(1 << (((c - 1) / 2) % 4)) : 4'b0;
      checks++; if (gnt !== exp) begin errors++; $display("FAIL fair_gnt c=%0d: got %b expected %b", c, gnt, exp); end
      tick();
    end
    req = '0; last = '0;
  endtask

  task automatic test_burst();
    do_reset();
    req = 4'b0100; a_arr[2] = 4'hA; last = '0; y_ready = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      if (c == 3) last = 4'b0100;
      if (c == 4) begin last = '0; req = '0; end
      settle();
      if (c >= 1 && c <= 3) begin
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL burst_gnt c=%0d: got %b expected 0100", c, gnt); end
        checks++; if (y !== 4'hA) begin errors++; $display("FAIL burst_y c=%0d: got %h expected a", c, y); end
        checks++; if ({s1, s0} !== 2'b10) begin errors++; $display("FAIL burst_sel c=%0d: got %b expected 10", c, {s1, s0}); end
        checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL burst_valid c=%0d: got %b expected 1", c, y_valid); end
      end else if (c == 4) begin
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL burst_end_gnt: got %b expected 0000", gnt); end
        checks++; if ({s1, s0} !== 2'b10) begin errors++; $display("FAIL burst_end_sel: got %b expected 10 (held)", {s1, s0}); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 4'b0010; a_arr[1] = 4'h5; last = '0; y_ready = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      // Stall with last already asserted: nothing may transfer until ready.
      if (c >= 2 && c <= 4) begin y_ready = 1'b0; last = 4'b0010; end
      if (c == 5) y_ready = 1'b1;
      settle();
      if (c >= 2 && c <= 5) begin
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL bp_gnt c=%0d: got %b expected 0010", c, gnt); end
        checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c=%0d: got %b expected 1", c, y_valid); end
        checks++; if (y !== 4'h5) begin errors++; $display("FAIL bp_y c=%0d: got %h expected 5", c, y); end
      end else if (c == 6) begin
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL bp_release: got %b expected 0000", gnt); end
      end
      tick();
    end
    req = '0; last = '0;
  endtask

  task automatic test_abort();
    do_reset();
    req = 4'b0010; last = '0; y_ready = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      if (c == 2) begin req = 4'b0000; last = 4'b0010; end
      if (c == 3) begin req = 4'b1111; last = 4'b0000; end
      settle();
      if (c == 1) begin
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL abort_grant: got %b expected 0010", gnt); end
      end
      if (c == 2) begin
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", y_valid); end
      end
      if (c == 3) begin
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL abort_release: got %b expected 0000", gnt); end
      end
      if (c == 4) begin
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL abort_next_ptr: got %b expected 0100", gnt); end
      end
      tick();
    end
    req = '0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b1111; last = 4'b0001; y_ready = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      if (c == 4) rst = 1'b1;
      if (c == 5) rst = 1'b0;
      settle();
      if (c == 4) begin
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rstmid_busy: got %b expected 0010", gnt); end
      end
      if (c == 5) begin
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rstmid_gnt: got %b expected 0000", gnt); end
        checks++; if ({s1, s0} !== 2'b00) begin errors++; $display("FAIL rstmid_sel: got %b expected 00", {s1, s0}); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", y_valid); end
      end
      if (c == 6) begin
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_first: got %b expected 0001", gnt); end
      end
      tick();
    end
    req = '0; last = '0;
  endtask

  task automatic test_timeout();
    int  run;
    bit  ended;
    int  exp_run;
    do_reset();
    req = 4'b0001; last = '0; y_ready = 1'b1;
    run = 0; ended = 1'b0;
    exp_run = TIMEOUT ? MAX_BURST : 23;
    for (int c = 0; c < 24; c++) begin
      settle();
      checks++; if (gnt !== exp_gnt()) begin errors++; $display("FAIL timeout_gnt c=%0d: got %b expected %b", c, gnt, exp_gnt()); end
      if (gnt == 4'b0001 && !ended) run++;
      else if (run > 0) ended = 1'b1;
      tick();
    end
    checks++; if (run !== exp_run) begin errors++; $display("FAIL timeout_run: got %0d expected %0d", run, exp_run); end
    req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req     = 4'($urandom | $urandom);
      last    = 4'($urandom & $urandom);
      y_ready = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 4; i++) a_arr[i] = WIDTH'($urandom);
      settle();
      checks++; if (gnt !== exp_gnt()) begin errors++; $display("FAIL rand_gnt c=%0d: got %b expected %b", c, gnt, exp_gnt()); end
      checks++; if ({s1, s0} !== exp_sel()) begin errors++; $display("FAIL rand_sel c=%0d: got %b expected %b", c, {s1, s0}, exp_sel()); end
      checks++; if (y_valid !== exp_valid()) begin errors++; $display("FAIL rand_valid c=%0d: got %b expected %b", c, y_valid, exp_valid()); end
      checks++; if (y !== exp_y()) begin errors++; $display("FAIL rand_y c=%0d: got %h expected %h", c, y, exp_y()); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) a_arr[i] = '0;
    test_reset();
    test_fairness();
    test_burst();
    test_backpressure();
    test_abort();
    test_reset_mid_burst();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
